ysyx_210247_axi_mux: RTL
========================

Name: ysyx_210247_axi_mux

Overview:
- N-port round-robin arbiter and AXI4 master bridge.
- Generalises the fixed two-port (inst/data) bridge: any number of cache or uncached requesters share one AXI4 master.
- Supports INCR bursts of 1–256 beats for both reads and writes, per-port AXI ID tagging, and error reporting.
- Sits between the icache/dcache/MMIO request ports and the SoC AXI interface; one transaction is outstanding at a time.

Parameters:
NPORT, 2, number of requester ports (1..8)
ADDR_W, 64, address width
DATA_W, 64, AXI data width; STRB_W = DATA_W/8
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NPORT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
req_valid  in  NPORT  per-port request valid
req_ready  out  NPORT  one-hot pulse: request accepted (granted)
req_wen  in  NPORT  1=write, 0=read
req_addr  in  NPORT*ADDR_W  start address, port i at [i*ADDR_W +: ADDR_W]
req_size  in  NPORT*3  AXI size code
req_len  in  NPORT*8  beats-1
req_strb  in  NPORT*STRB_W  write strobe, applied to every beat
req_wdata  in  NPORT*DATA_W  current write beat; held by port until wbeat_ack
wbeat_ack  out  NPORT  pulse: current write beat accepted; port presents next beat next cycle
rdata  out  DATA_W  read beat data, shared bus
rvalid  out  NPORT  one-hot: rdata valid for port i
rlast  out  1  final read beat, qualified by rvalid
resp_done  out  NPORT  one-hot pulse: transaction complete
resp_err  out  1  error flag, qualified by resp_done
aw_valid/aw_ready/aw_addr/aw_id/aw_len/aw_size/aw_burst  AXI4 AW channel, master side
w_valid/w_ready/w_data/w_strb/w_last  AXI4 W channel
b_valid/b_ready/b_resp/b_id  AXI4 B channel
ar_valid/ar_ready/ar_addr/ar_id/ar_len/ar_size/ar_burst  AXI4 AR channel
r_valid/r_ready/r_data/r_resp/r_last/r_id  AXI4 R channel
- prot/lock/cache/qos/user are not generated by this block; they are tied off at top level.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rr_ptr=0.
  - All valid/ready/ack/done outputs 0; addr/id/len/size outputs 0; resp_err=0.
  - Reset mid-transaction abandons it without draining AXI.
- States: IDLE, AR, R, AW_W, B.
- IDLE arbitration:
  - Combinational search over req_valid starting at rr_ptr, wrapping mod NPORT.
  - If any request is valid: req_ready[g]=1 in the same cycle, request fields latched, grant g latched, rr_ptr <= (g+1) mod NPORT.
  - Next state: AR if read, AW_W if write.
  - No valid request: stay in IDLE.
- AR:
  - ar_valid=1 with latched addr, len, size; burst=INCR (2'b01); id=g.
  - On ar_ready → R.
  - AR valid is first visible the cycle after acceptance; ar_valid stays asserted until ready (AXI-stable).
- R:
  - r_ready=1. Each r_valid: rdata=r_data, rvalid[g]=1, rlast=r_last.
  - Beat counter increments per beat.
  - err_sticky sets on r_resp!=0, on r_id!=g, or on r_last arriving when beat count != len.
  - On r_last: resp_done[g]=1, resp_err=err_sticky (including the current beat) → IDLE.
- AW_W:
  - aw_valid and w_valid are asserted concurrently.
  - aw_done is set on aw_ready and aw_valid then drops.
  - w_data = req_wdata slice g (live); w_strb = latched strb; w_last = (wcnt==len).
  - On w_valid&w_ready: wbeat_ack[g]=1, wcnt++. After the last beat, w_valid drops.
  - When aw_done and the last W beat are both complete (either order, or the same cycle) → B.
- B:
  - b_ready=1. On b_valid: resp_done[g]=1, resp_err = (b_resp!=0) | (b_id!=g) → IDLE.
- Simultaneous requests: lowest index at or after rr_ptr wins. Consecutive requests from all ports are served strictly rotating.
- A new grant occurs no earlier than the cycle after resp_done (single outstanding transaction).
- len=0: single beat; w_last / expected r_last on the first beat.
- len=255: the 8-bit beat counter must reach 255 without wrap-around errors.
- Unused outputs hold 0 outside their states. resp_err is 0 whenever resp_done is 0.

Test Plan:
- Single read, port 0, addr 0x8000_0000, len 3, size 3:
  - One req_ready[0] pulse; AR one cycle later with id=0, len=3, burst=1.
  - Four rvalid[0] beats, rlast on the 4th; resp_done[0] with err=0.
- Write, port 1, len 1, data A then B, strb 0xFF; aw_ready delayed 3 cycles, w_ready immediate:
  - Both W beats complete first; w_last on beat 2; two wbeat_ack[1] pulses.
  - B state entered only after AW handshake; b_resp=0 → resp_done[1], err=0.
- NPORT=3, all req_valid held high for 6 transactions:
  - Grant order 0,1,2,0,1,2; never two req_ready bits in the same cycle.
- Error paths:
  - Read with r_resp=2 on beat 1 of 2 → resp_err=1 at rlast.
  - Read with r_last on beat 1 when len=3 → resp_err=1.
  - Write with b_resp=3 → resp_err=1.
- Reset asserted mid-R burst (after 2 of 4 beats):
  - All outputs 0 immediately, asynchronously.
  - After release, port 1 request is granted first because rr_ptr=0 and port 0 is idle; behaviour is normal.
- len=255 read: 256 beats, rlast only on beat 256, err=0.

Source files
------------

// File: rtl/ysyx_210247_axi_mux.sv
// rtl/ysyx_210247_axi_mux.sv - N-port round-robin arbiter and single-outstanding AXI4 master bridge
//
// Purpose: shares one AXI4 master between NPORT cache/uncached requesters.
// One transaction (INCR burst, 1..256 beats) is in flight at a time; the
// granted port index doubles as the AXI ID.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   req_*                        per-port request (packed, port i at slice i)
//   req_ready / wbeat_ack        one-hot grant pulse / write-beat accept pulse
//   rdata, rvalid, rlast         read beat return (shared data, one-hot valid)
//   resp_done, resp_err          one-hot completion pulse and its error flag
//   aw_*, w_*, b_*, ar_*, r_*    AXI4 master channels
module ysyx_210247_axi_mux #(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPORT-1:0]          req_valid,
  output logic [NPORT-1:0]          req_ready,
  input  logic [NPORT-1:0]          req_wen,
  input  logic [NPORT*ADDR_W-1:0]   req_addr,
  input  logic [NPORT*3-1:0]        req_size,
  input  logic [NPORT*8-1:0]        req_len,
  input  logic [NPORT*STRB_W-1:0]   req_strb,
  input  logic [NPORT*DATA_W-1:0]   req_wdata,
  output logic [NPORT-1:0]          wbeat_ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [NPORT-1:0]          rvalid,
  output logic                      rlast,
  output logic [NPORT-1:0]          resp_done,
  output logic                      resp_err,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [ADDR_W-1:0]         aw_addr,
  output logic [ID_W-1:0]           aw_id,
  output logic [7:0]                aw_len,
  output logic [2:0]                aw_size,
  output logic [1:0]                aw_burst,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [DATA_W-1:0]         w_data,
  output logic [STRB_W-1:0]         w_strb,
  output logic                      w_last,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [1:0]                b_resp,
  input  logic [ID_W-1:0]           b_id,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [ADDR_W-1:0]         ar_addr,
  output logic [ID_W-1:0]           ar_id,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [DATA_W-1:0]         r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last,
  input  logic [ID_W-1:0]           r_id
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [2:0]           size_q, size_d;
  logic [7:0]           len_q, len_d;
  logic [STRB_W-1:0]    strb_q, strb_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;

  // Per-port views of the packed request buses.
  logic [ADDR_W-1:0]    addr_a  [NPORT];
  logic [2:0]           size_a  [NPORT];
  logic [7:0]           len_a   [NPORT];
  logic [STRB_W-1:0]    strb_a  [NPORT];
  logic [DATA_W-1:0]    wdata_a [NPORT];

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      size_a[i]  = req_size[i*3 +: 3];
      len_a[i]   = req_len[i*8 +: 8];
      strb_a[i]  = req_strb[i*STRB_W +: STRB_W];
      wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: walk from the farthest candidate back to rr_ptr so the
  // last hit is the closest valid port at or after the pointer.
  logic          found;
  logic [PW-1:0] gsel;
  logic [PW:0]   arb_sum;
  logic [PW:0]   next_sum;

  always_comb begin
    found   = 1'b0;
    gsel    = '0;
    arb_sum = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(NPORT)) arb_sum = arb_sum - (PW+1)'(NPORT);
      if (req_valid[arb_sum[PW-1:0]]) begin
        found = 1'b1;
        gsel  = arb_sum[PW-1:0];
      end
    end
    next_sum = {1'b0, gsel} + (PW+1)'(1);
    if (next_sum >= (PW+1)'(NPORT)) next_sum = '0;
  end

  logic [NPORT-1:0] gmask;
  logic [ID_W-1:0]  gid;
  logic             beat_err;

  assign gmask = NPORT'(1) << grant_q;
  assign gid   = ID_W'(grant_q);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    size_d    = size_q;
    len_d     = len_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    beat_err  = 1'b0;
    req_ready = '0;
    wbeat_ack = '0;
    rdata     = '0;
    rvalid    = '0;
    rlast     = 1'b0;
    resp_done = '0;
    resp_err  = 1'b0;
    aw_valid  = 1'b0;
    aw_addr   = '0;
    aw_id     = '0;
    aw_len    = '0;
    aw_size   = '0;
    aw_burst  = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    w_strb    = '0;
    w_last    = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    ar_addr   = '0;
    ar_id     = '0;
    ar_len    = '0;
    ar_size   = '0;
    ar_burst  = '0;
    r_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found && !reset) begin
          req_ready = NPORT'(1) << gsel;
          grant_d   = gsel;
          rr_ptr_d  = next_sum[PW-1:0];
          addr_d    = addr_a[gsel];
          size_d    = size_a[gsel];
          len_d     = len_a[gsel];
          strb_d    = strb_a[gsel];
          cnt_d     = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen[gsel] ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        ar_addr  = addr_q;
        ar_id    = gid;
        ar_len   = len_q;
        ar_size  = size_q;
        ar_burst = 2'b01;
        if (ar_ready) state_d = S_R;
      end
      S_R: begin
        r_ready = 1'b1;
        if (r_valid) begin
          rdata    = r_data;
          rvalid   = gmask;
          rlast    = r_last;
          cnt_d    = cnt_q + 8'd1;
          beat_err = (r_resp != 2'b00) || (r_id != gid) || (r_last && (cnt_q != len_q));
          err_d    = err_q | beat_err;
          if (r_last) begin
            resp_done = gmask;
            resp_err  = err_q | beat_err;
            state_d   = S_IDLE;
          end
        end
      end
      S_AW_W: begin
        aw_valid = !aw_done_q;
        if (aw_valid) begin
          aw_addr  = addr_q;
          aw_id    = gid;
          aw_len   = len_q;
          aw_size  = size_q;
          aw_burst = 2'b01;
          if (aw_ready) aw_done_d = 1'b1;
        end
        w_valid = !w_done_q;
        if (w_valid) begin
          // Write data is taken live from the port, which holds each beat until acked.
          w_data = wdata_a[grant_q];
          w_strb = strb_q;
          w_last = (cnt_q == len_q);
          if (w_ready) begin
            wbeat_ack = gmask;
            cnt_d     = cnt_q + 8'd1;
            if (w_last) w_done_d = 1'b1;
          end
        end
        // AW and the final W beat may finish in either order or together.
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          resp_done = gmask;
          resp_err  = (b_resp != 2'b00) || (b_id != gid);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      len_q     <= len_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
